// File: rtl/paint_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : paint_scheduler
// Brief    : Buffers brush/clear commands in a FIFO and turns each one into
//            one-pixel-per-clock writes, clipped to the visible area.
//            Optional PAINT_BLANK_ONLY_EN restricts writes to active = 0.
// Revision : 1.0  initial release
// ============================================================================
module paint_scheduler #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_x,
    input  logic [9:0] cmd_y,
    input  logic [2:0] cmd_color,
    input  logic [1:0] cmd_size,
    input  logic       cmd_clear,
    input  logic       active,
    output logic       wen,
    output logic [9:0] wx,
    output logic [9:0] wy,
    output logic [2:0] wcolor,
    output logic       busy
);

    localparam int                 c_ptr_w      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_ptr_w:0]   c_count_full = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic signed [11:0] c_h_lim      = 12'(H_RES);
    localparam logic signed [11:0] c_v_lim      = 12'(V_RES);
    localparam logic [9:0]         c_x_last     = 10'(H_RES - 1);
    localparam logic [9:0]         c_y_last     = 10'(V_RES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PAINT = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t r_state, w_state_next;

    // Command FIFO: entry = {clear, color, size, y, x}
    logic [25:0]        r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_full, w_empty, w_push, w_pop;
    logic [25:0]        w_head;

    assign w_full    = (r_count == c_count_full);
    assign w_empty   = (r_count == '0);
    assign cmd_ready = ~w_full;
    assign w_push    = cmd_valid & ~w_full;
    assign w_pop     = (r_state == S_IDLE) & ~w_empty;
    assign w_head    = r_mem[r_rd_ptr];
    assign busy      = (r_state != S_IDLE) | ~w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_clear, cmd_color, cmd_size, cmd_y, cmd_x};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Working registers for the command being expanded
    logic [9:0]        r_x, r_y, r_cx, r_cy;
    logic [2:0]        r_color;
    logic [1:0]        r_size;
    logic signed [3:0] r_dx, r_dy;
    logic signed [3:0] w_r, w_head_neg_r;
    logic signed [11:0] w_px, w_py;
    logic              w_in_range, w_advance;

    assign w_r          = $signed({2'b00, r_size});
    assign w_head_neg_r = 4'sd0 - $signed({2'b00, w_head[21:20]});
    assign w_px         = $signed({2'b00, r_x}) + $signed({{8{r_dx[3]}}, r_dx});
    assign w_py         = $signed({2'b00, r_y}) + $signed({{8{r_dy[3]}}, r_dy});
    assign w_in_range   = ~w_px[11] && (w_px < c_h_lim) && ~w_py[11] && (w_py < c_v_lim);

`ifdef PAINT_BLANK_ONLY_EN
    assign w_advance = ~active;
`else
    logic w_unused_active;
    assign w_unused_active = active;
    assign w_advance       = 1'b1;
`endif

    always_comb begin
        w_state_next = r_state;
        wen          = 1'b0;
        wx           = 10'd0;
        wy           = 10'd0;
        wcolor       = 3'd0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next = w_head[25] ? S_CLEAR : S_PAINT;
                end
            end
            S_PAINT: begin
                wcolor = r_color;
                if (w_advance) begin
                    // Out-of-range points still consume their cycle
                    if (w_in_range) begin
                        wen = 1'b1;
                        wx  = w_px[9:0];
                        wy  = w_py[9:0];
                    end
                    if ((r_dx == w_r) && (r_dy == w_r)) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_CLEAR: begin
                wcolor = r_color;
                if (w_advance) begin
                    wen = 1'b1;
                    wx  = r_cx;
                    wy  = r_cy;
                    if ((r_cx == c_x_last) && (r_cy == c_y_last)) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
            r_size  <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_x     <= w_head[9:0];
                        r_y     <= w_head[19:10];
                        r_size  <= w_head[21:20];
                        r_color <= w_head[24:22];
                        r_dx    <= w_head_neg_r;
                        r_dy    <= w_head_neg_r;
                        r_cx    <= '0;
                        r_cy    <= '0;
                    end
                end
                S_PAINT: begin
                    if (w_advance) begin
                        if (r_dx == w_r) begin
                            r_dx <= 4'sd0 - w_r;
                            r_dy <= r_dy + 4'sd1;
                        end else begin
                            r_dx <= r_dx + 4'sd1;
                        end
                    end
                end
                S_CLEAR: begin
                    if (w_advance) begin
                        if (r_cx == c_x_last) begin
                            r_cx <= '0;
                            r_cy <= r_cy + 10'd1;
                        end else begin
                            r_cx <= r_cx + 10'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_paint_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_paint_scheduler
// Brief    : Self-checking bench for paint_scheduler using a list-based model
//            of the expected per-cycle write stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_paint_scheduler;

    localparam int H = 128;
    localparam int V = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [9:0] cmd_x = '0;
    logic [9:0] cmd_y = '0;
    logic [2:0] cmd_color = '0;
    logic [1:0] cmd_size = '0;
    logic       cmd_clear = 1'b0;
    logic       active = 1'b0;
    logic       wen;
    logic [9:0] wx, wy;
    logic [2:0] wcolor;
    logic       busy;

    int tests = 0;
    int fails = 0;

    typedef struct {logic wen; int x; int y; int c;} pt_t;
    pt_t exp_q[$];
    pt_t obs_q[$];

    paint_scheduler #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color), .cmd_size(cmd_size),
        .cmd_clear(cmd_clear), .active(active), .wen(wen), .wx(wx), .wy(wy),
        .wcolor(wcolor), .busy(busy)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected per-cycle stream of one command, appended to exp_q
    task automatic add_expect(input int x, input int y, input int c, input int r, input logic clr);
        if (clr) begin
            for (int cy = 0; cy < V; cy++)
                for (int cx = 0; cx < H; cx++)
                    exp_q.push_back('{1'b1, cx, cy, c});
        end else begin
            for (int dy = -r; dy <= r; dy++)
                for (int dx = -r; dx <= r; dx++) begin
                    int px = x + dx;
                    int py = y + dy;
                    if (px >= 0 && px < H && py >= 0 && py < V)
                        exp_q.push_back('{1'b1, px, py, c});
                    else
                        exp_q.push_back('{1'b0, 0, 0, c});
                end
        end
    endtask

    task automatic drive_cmd(input int x, input int y, input int c, input int r, input logic clr);
        cmd_x = 10'(x); cmd_y = 10'(y); cmd_color = 3'(c); cmd_size = 2'(r);
        cmd_clear = clr; cmd_valid = 1'b1;
    endtask

    task automatic run_cmd(input int x, input int y, input int c, input int r, input logic clr);
        int idx = 0, cyc = 0, nw = 0, ew = 0, limit;
        logic stall;
        exp_q.delete();
        add_expect(x, y, c, r, clr);
        foreach (exp_q[i]) if (exp_q[i].wen) ew++;
        limit = 3 * exp_q.size() + 64;
        @(negedge clk);
        drive_cmd(x, y, c, r, clr);
        #1 check("ready", 32'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("lat_wen", 32'(wen), 0);
        check("lat_busy", 32'(busy), 1);
        while (idx < exp_q.size()) begin
            @(negedge clk);
            active = 1'($urandom_range(0, 1));
            #1;
            cyc++;
            if (cyc > limit) begin
                check("timeout", 32'(idx), 32'(exp_q.size()));
                break;
            end
            stall = 1'b0;
`ifdef PAINT_BLANK_ONLY_EN
            stall = active;
`endif
            if (stall) begin
                check("stall_wen", 32'(wen), 0);
            end else begin
                check("wen", 32'(wen), 32'(exp_q[idx].wen));
                check("wx", 32'(wx), exp_q[idx].x);
                check("wy", 32'(wy), exp_q[idx].y);
                check("wcolor", 32'(wcolor), c);
                if (wen === 1'b1) nw++;
                idx++;
            end
            check("busy", 32'(busy), 1);
        end
        active = 1'b0;
        @(negedge clk);
        check("end_wen", 32'(wen), 0);
        check("end_busy", 32'(busy), 0);
        check("end_color", 32'(wcolor), 0);
        check("nwrites", 32'(nw), 32'(ew));
    endtask

    initial begin
        int accepted, first_low, cyc;
        logic rdy;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wen", 32'(wen), 0);
        check("rst_wx", 32'(wx), 0);
        check("rst_wy", 32'(wy), 0);
        check("rst_color", 32'(wcolor), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(cmd_ready), 1);
        reset = 1'b0;

        // Directed paints: nominal, corner, far edge, off-screen, r = 0
        run_cmd(100, 50, 5, 1, 1'b0);
        run_cmd(0, 0, 3, 3, 1'b0);
        run_cmd(H - 1, V - 1, 6, 2, 1'b0);
        run_cmd(1000, 1000, 7, 2, 1'b0);
        run_cmd(17, 9, 1, 0, 1'b0);

        // Randomized paints, occasionally off-screen
        for (int i = 0; i < 16; i++) begin
            int x, y;
            x = ($urandom_range(0, 5) == 0) ? int'($urandom_range(H - 2, 1023)) : int'($urandom_range(0, H - 1));
            y = ($urandom_range(0, 5) == 0) ? int'($urandom_range(V - 2, 1023)) : int'($urandom_range(0, V - 1));
            run_cmd(x, y, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b0);
        end

        // Full-screen clear
        run_cmd(0, 0, 2, 0, 1'b1);

        // Reset during the 5th write cycle of a paint
        exp_q.delete();
        add_expect(100, 50, 5, 1, 1'b0);
        @(negedge clk);
        drive_cmd(100, 50, 5, 1, 1'b0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("rs_lat_wen", 32'(wen), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rs_wen", 32'(wen), 32'(exp_q[k].wen));
            check("rs_wx", 32'(wx), exp_q[k].x);
            check("rs_wy", 32'(wy), exp_q[k].y);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rs_after_wen", 32'(wen), 0);
        check("rs_after_wx", 32'(wx), 0);
        check("rs_after_color", 32'(wcolor), 0);
        check("rs_after_busy", 32'(busy), 0);
        check("rs_after_ready", 32'(cmd_ready), 1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("rs_quiet_wen", 32'(wen), 0);
        end

        // Backpressure: long paint, then six r = 0 commands with valid held
        exp_q.delete();
        obs_q.delete();
        add_expect(60, 30, 1, 3, 1'b0);
        for (int i = 0; i < 6; i++) add_expect(10 + 7 * i, 3 + i, (i + 2) % 8, 0, 1'b0);
        @(negedge clk);
        drive_cmd(60, 30, 1, 3, 1'b0);
        @(posedge clk);
        #1 drive_cmd(10, 3, 2, 0, 1'b0);
        accepted = 0;
        first_low = -1;
        cyc = 0;
        forever begin
            @(negedge clk);
            active = 1'($urandom_range(0, 1));
            #1;
            if (wen === 1'b1) obs_q.push_back('{1'b1, int'(wx), int'(wy), int'(wcolor)});
            if (accepted == 6 && busy === 1'b0) break;
            cyc++;
            if (cyc > 1000) begin
                check("bp_timeout", 32'(accepted), 6);
                break;
            end
            rdy = cmd_ready;
            if (rdy !== 1'b1 && first_low < 0) first_low = accepted;
            @(posedge clk);
            if (cmd_valid && rdy === 1'b1) accepted++;
            #1;
            if (accepted < 6) drive_cmd(10 + 7 * accepted, 3 + accepted, (accepted + 2) % 8, 0, 1'b0);
            else cmd_valid = 1'b0;
        end
        active = 1'b0;
        check("bp_ready_drop", 32'(first_low), 4);
        check("bp_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check("bp_x", 32'(obs_q[i].x), exp_q[i].x);
            check("bp_y", 32'(obs_q[i].y), exp_q[i].y);
            check("bp_c", 32'(obs_q[i].c), exp_q[i].c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
